issue_buffer: RTL and testbench

ISSUE_BUFFER -- requirements
Module: issue_buffer

---
 rtl/issue_buffer.sv | 125 ++++++++++++
 tb/tb_issue_buffer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/issue_buffer.sv
// Circular issue buffer: multi-lane in-order enqueue, hazard-limited in-order issue groups.
// Define ISSUE_BUFFER_STAT_EN to add the issue_cnt_o / hazard_cnt_o statistics outputs.
module issue_buffer #(
  parameter int IN_W    = 2,
  parameter int ISSUE_W = 2,
  parameter int DEPTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IN_W-1:0]        pre_valid_i,
  input  logic [IN_W*83-1:0]     pre_to_ibus,
  output logic                   now_allowin_o,
  input  logic                   next_allowin_i,
  output logic [ISSUE_W-1:0]     next_valid_o,
  output logic [ISSUE_W*83-1:0]  to_next_obus,
  input  logic                   excep_flush_i,
  input  logic                   branch_flush_i
`ifdef ISSUE_BUFFER_STAT_EN
  ,
  output logic [31:0]            issue_cnt_o,
  output logic [31:0]            hazard_cnt_o
`endif
);

  localparam int ENTRY_W = 83;
  localparam int PW      = $clog2(DEPTH);
  localparam int CNT_W   = PW + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PW-1:0]      head, tail;
  logic [CNT_W-1:0]   count;

  logic               flush, do_enq, do_issue, run, stop, ok;
  logic [CNT_W-1:0]   enq_n, k, avail, enq_add, iss_sub;
  logic [ENTRY_W-1:0] ent [ISSUE_W];

  assign flush         = excep_flush_i | branch_flush_i;
  assign now_allowin_o = (count <= CNT_W'(DEPTH - IN_W));
  assign do_enq        = now_allowin_o & ~flush;
  assign do_issue      = next_allowin_i & ~flush;
  assign enq_add       = do_enq ? enq_n : '0;
  assign iss_sub       = do_issue ? k : '0;

  // Only the contiguous run of valid lanes starting at lane 0 is accepted.
  always_comb begin
    enq_n = '0;
    run   = 1'b1;
    for (int unsigned i = 0; i < IN_W; i++) begin
      if (run && pre_valid_i[i]) enq_n = CNT_W'(i + 1);
      else                       run   = 1'b0;
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < ISSUE_W; j++) ent[j] = mem[head + PW'(j)];
    avail = (int'(count) < ISSUE_W) ? count : CNT_W'(ISSUE_W);
  end

  // Group grows from the head until a solo entry or a register conflict with an earlier member.
  always_comb begin
    k    = (count != '0) ? CNT_W'(1) : '0;
    stop = 1'b0;
    ok   = 1'b0;
    for (int unsigned j = 1; j < ISSUE_W; j++) begin
      ok = !stop && (CNT_W'(j) < count) && !ent[j][82] && !ent[0][82];
      for (int unsigned e = 0; e < j; e++) begin
        if (ent[e][81] && ent[e][80:76] != 5'd0) begin
          if (ent[j][69] && ent[e][80:76] == ent[j][68:64]) ok = 1'b0;
          if (ent[j][75] && ent[e][80:76] == ent[j][74:70]) ok = 1'b0;
          if (ent[j][81] && ent[e][80:76] == ent[j][80:76]) ok = 1'b0;
        end
      end
      if (ok) k    = CNT_W'(j + 1);
      else    stop = 1'b1;
    end
  end

  always_comb begin
    next_valid_o = '0;
    to_next_obus = '0;
    for (int unsigned i = 0; i < ISSUE_W; i++) begin
      if (CNT_W'(i) < k) begin
        next_valid_o[i]                        = ~flush;
        to_next_obus[i*ENTRY_W +: ENTRY_W]     = ent[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_enq)   tail <= tail + PW'(enq_n);
      if (do_issue) head <= head + PW'(k);
      count <= count + enq_add - iss_sub;
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq && !rst) begin
      for (int unsigned i = 0; i < IN_W; i++) begin
        if (CNT_W'(i) < enq_n) mem[tail + PW'(i)] <= pre_to_ibus[i*ENTRY_W +: ENTRY_W];
      end
    end
  end

`ifdef ISSUE_BUFFER_STAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt_o  <= '0;
      hazard_cnt_o <= '0;
    end else if (do_issue) begin
      issue_cnt_o <= issue_cnt_o + 32'(k);
      if (k < avail) hazard_cnt_o <= hazard_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_buffer.sv
// Directed bench for issue_buffer (IN_W=2, ISSUE_W=2, DEPTH=8); stats checked when ISSUE_BUFFER_STAT_EN is defined.
module tb_issue_buffer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   pre_valid_i = '0;
  logic [165:0] pre_to_ibus = '0;
  logic         now_allowin_o;
  logic         next_allowin_i = 1'b0;
  logic [1:0]   next_valid_o;
  logic [165:0] to_next_obus;
  logic         excep_flush_i = 1'b0;
  logic         branch_flush_i = 1'b0;
`ifdef ISSUE_BUFFER_STAT_EN
  logic [31:0]  issue_cnt_o, hazard_cnt_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  issue_buffer #(.IN_W(2), .ISSUE_W(2), .DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .pre_valid_i(pre_valid_i), .pre_to_ibus(pre_to_ibus),
    .now_allowin_o(now_allowin_o), .next_allowin_i(next_allowin_i),
    .next_valid_o(next_valid_o), .to_next_obus(to_next_obus),
    .excep_flush_i(excep_flush_i), .branch_flush_i(branch_flush_i)
`ifdef ISSUE_BUFFER_STAT_EN
    , .issue_cnt_o(issue_cnt_o), .hazard_cnt_o(hazard_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [82:0] mk(input logic solo, input logic we, input logic [4:0] wa,
                                     input logic re2, input logic [4:0] ra2,
                                     input logic re1, input logic [4:0] ra1, input logic [31:0] pc);
    return {solo, we, wa, re2, ra2, re1, ra1, pc, pc ^ 32'h0000_0013};
  endfunction

  task automatic enq(input logic [1:0] v, input logic [82:0] l1, input logic [82:0] l0);
    pre_valid_i = v;
    pre_to_ibus = {l1, l0};
    tick();
    pre_valid_i = '0;
  endtask

  logic [82:0] a, b, c, d, c0, d0, ld, ad, ad2, so2;

  initial begin
    a   = mk(0, 1, 5'd3,  1, 5'd2, 1, 5'd1, 32'h100);
    b   = mk(0, 1, 5'd4,  1, 5'd6, 1, 5'd5, 32'h104);
    c   = mk(0, 1, 5'd3,  0, 5'd0, 0, 5'd0, 32'h200);
    d   = mk(0, 1, 5'd7,  0, 5'd0, 1, 5'd3, 32'h204);
    c0  = mk(0, 1, 5'd0,  0, 5'd0, 0, 5'd0, 32'h210);
    d0  = mk(0, 1, 5'd8,  0, 5'd0, 1, 5'd0, 32'h214);
    ld  = mk(1, 1, 5'd9,  0, 5'd0, 1, 5'd1, 32'h300);
    ad  = mk(0, 1, 5'd10, 1, 5'd2, 1, 5'd1, 32'h304);
    ad2 = mk(0, 1, 5'd11, 0, 5'd0, 1, 5'd1, 32'h310);
    so2 = mk(1, 1, 5'd12, 0, 5'd0, 1, 5'd2, 32'h314);

    #1;
    check("rst_valid", next_valid_o, 2'b00);
    check("rst_obus", to_next_obus, '0);
    check("rst_allowin", now_allowin_o, 1'b1);
    check("rst_count", dut.count, 0);
`ifdef ISSUE_BUFFER_STAT_EN
    check("rst_issue_cnt", issue_cnt_o, 0);
`endif
    tick();
    rst = 1'b0;

    // independent pair
    next_allowin_i = 1'b1;
    pre_valid_i = 2'b11; pre_to_ibus = {b, a};
    #1 check("pair_empty_valid", next_valid_o, 2'b00);
    tick(); pre_valid_i = '0;
    check("pair_valid", next_valid_o, 2'b11);
    check("pair_obus", to_next_obus, {b, a});
    tick();
    check("pair_count", dut.count, 0);
    check("pair_valid_after", next_valid_o, 2'b00);

    // RAW hazard on r3
    enq(2'b11, d, c);
    check("raw_valid1", next_valid_o, 2'b01);
    check("raw_obus1", to_next_obus, {83'd0, c});
    tick();
    check("raw_valid2", next_valid_o, 2'b01);
    check("raw_obus2", to_next_obus, {83'd0, d});
    tick();
    check("raw_count", dut.count, 0);
`ifdef ISSUE_BUFFER_STAT_EN
    check("stat_issue4", issue_cnt_o, 4);
    check("stat_hazard1", hazard_cnt_o, 1);
`endif

    // r0 writes never conflict
    enq(2'b11, d0, c0);
    check("r0_valid", next_valid_o, 2'b11);
    check("r0_obus", to_next_obus, {d0, c0});
    tick();

    // solo first, then solo second
    enq(2'b11, ad, ld);
    check("solo1_a", to_next_obus, {83'd0, ld});
    check("solo1_av", next_valid_o, 2'b01);
    tick();
    check("solo1_b", to_next_obus, {83'd0, ad});
    tick();
    enq(2'b11, so2, ad2);
    check("solo2_a", to_next_obus, {83'd0, ad2});
    check("solo2_av", next_valid_o, 2'b01);
    tick();
    check("solo2_b", to_next_obus, {83'd0, so2});
    check("solo2_bv", next_valid_o, 2'b01);
    tick();
    check("solo_count", dut.count, 0);

    // fill to DEPTH with issue stalled; tail wraps (started at 2)
    next_allowin_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      enq(2'b11, mk(0, 0, 0, 0, 0, 0, 0, 32'h404 + 32'(8*i)), mk(0, 0, 0, 0, 0, 0, 0, 32'h400 + 32'(8*i)));
      check("fill_count", dut.count, 2*(i+1));
      check("fill_allowin", now_allowin_o, (i < 3) ? 1'b1 : 1'b0);
    end
    pre_valid_i = 2'b11; pre_to_ibus = {mk(0,0,0,0,0,0,0,32'h4F4), mk(0,0,0,0,0,0,0,32'h4F0)};
    tick(); pre_valid_i = '0;
    check("full_drop_count", dut.count, 8);
    check("full_hold_valid", next_valid_o, 2'b11);
`ifdef ISSUE_BUFFER_STAT_EN
    check("stat_hold_issue", issue_cnt_o, 10);
`endif
    next_allowin_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_allowin", now_allowin_o, (i == 0) ? 1'b0 : 1'b1);
      check("drain_valid", next_valid_o, 2'b11);
      check("drain_obus", to_next_obus,
            {mk(0, 0, 0, 0, 0, 0, 0, 32'h404 + 32'(8*i)), mk(0, 0, 0, 0, 0, 0, 0, 32'h400 + 32'(8*i))});
      tick();
    end
    check("drain_count", dut.count, 0);
`ifdef ISSUE_BUFFER_STAT_EN
    check("stat_issue18", issue_cnt_o, 18);
    check("stat_hazard3", hazard_cnt_o, 3);
`endif

    // non-contiguous valid, then build count=5 and flush
    next_allowin_i = 1'b0;
    enq(2'b10, mk(0,0,0,0,0,0,0,32'h5F0), mk(0,0,0,0,0,0,0,32'h5F4));
    check("noncontig_count", dut.count, 0);
    enq(2'b11, mk(0,0,0,0,0,0,0,32'h504), mk(0,0,0,0,0,0,0,32'h500));
    enq(2'b11, mk(0,0,0,0,0,0,0,32'h50C), mk(0,0,0,0,0,0,0,32'h508));
    enq(2'b01, mk(0,0,0,0,0,0,0,32'h5EC), mk(0,0,0,0,0,0,0,32'h510));
    check("pre_flush_count", dut.count, 5);
    check("pre_flush_obus", to_next_obus, {mk(0,0,0,0,0,0,0,32'h504), mk(0,0,0,0,0,0,0,32'h500)});
    branch_flush_i = 1'b1; next_allowin_i = 1'b1;
    pre_valid_i = 2'b11; pre_to_ibus = {mk(0,0,0,0,0,0,0,32'h604), mk(0,0,0,0,0,0,0,32'h600)};
    #1 check("flush_valid", next_valid_o, 2'b00);
    tick();
    branch_flush_i = 1'b0; pre_valid_i = '0;
    check("flush_count", dut.count, 0);
    check("flush_next_valid", next_valid_o, 2'b00);
    check("flush_allowin", now_allowin_o, 1'b1);
`ifdef ISSUE_BUFFER_STAT_EN
    check("stat_flush_issue", issue_cnt_o, 18);
    check("stat_flush_hazard", hazard_cnt_o, 3);
`endif

    // both flushes together
    next_allowin_i = 1'b0;
    enq(2'b11, b, a);
    excep_flush_i = 1'b1; branch_flush_i = 1'b1;
    #1 check("dflush_valid", next_valid_o, 2'b00);
    tick();
    excep_flush_i = 1'b0; branch_flush_i = 1'b0;
    check("dflush_count", dut.count, 0);

    // asynchronous reset mid-operation
    enq(2'b11, b, a);
    check("mid_count", dut.count, 2);
    #2 rst = 1'b1;
    #1;
    check("arst_count", dut.count, 0);
    check("arst_valid", next_valid_o, 2'b00);
    check("arst_obus", to_next_obus, '0);
    check("arst_allowin", now_allowin_o, 1'b1);
`ifdef ISSUE_BUFFER_STAT_EN
    check("arst_issue_cnt", issue_cnt_o, 0);
    check("arst_hazard_cnt", hazard_cnt_o, 0);
`endif
    tick();
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
